// File: rtl/uart_loader_pkg.sv
// Shared definitions for the boot-time UART program loader: FSM state
// encodings, default status bytes and small state-classification helpers.
package uart_loader_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEN   = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_ACK   = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    localparam logic [7:0] DEF_ACK_BYTE = 8'hAA;
    localparam logic [7:0] DEF_ERR_BYTE = 8'h55;

    // States that issue receive requests to the uart
    function automatic logic is_rx_state(input logic [2:0] st);
        return (st == ST_LEN) || (st == ST_DATA);
    endfunction

    // States that issue the single status-byte transmit request
    function automatic logic is_tx_state(input logic [2:0] st);
        return (st == ST_ACK) || (st == ST_ERR);
    endfunction

endpackage

// File: rtl/uart_loader_byte_assembler.sv
// Collects four bytes LSB-first into a 32-bit word. The word output already
// includes the byte being accepted this cycle, so the consumer can act on the
// complete word in the same cycle that word_valid pulses.
module uart_loader_byte_assembler
    import uart_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic [31:0] shifted;

    // Shift path, next-state and the combinational view of the word
    always_comb begin
        shifted    = {byte_in, word_q[31:8]};
        word       = byte_valid ? shifted : word_q;
        word_valid = byte_valid && (cnt_q == 2'd3);
        cnt_d      = cnt_q;
        word_d     = word_q;
        if (clear) begin
            cnt_d  = 2'd0;
            word_d = 32'd0;
        end else if (byte_valid) begin
            cnt_d  = cnt_q + 2'd1;
            word_d = shifted;
        end
    end

    // Byte counter and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            word_q <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/uart_loader.sv
// Boot-time program loader. Reads a 32-bit little-endian word count N over
// the uart request interface, then N words, writing word k to instruction
// memory address k, and finally sends one status byte back.
//
// Handshake: a request (r_valid or t_valid) is a single-cycle pulse issued
// only while u_ready=1 and nothing is outstanding; the matching rx_done or
// tx_done closes it. Completion pulses with nothing outstanding are ignored.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int         ADDR_W   = 15,
    parameter logic [7:0] ACK_BYTE = DEF_ACK_BYTE,
    parameter logic [7:0] ERR_BYTE = DEF_ERR_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              u_ready,
    output logic              r_valid,
    input  logic              rx_done,
    input  logic [7:0]        r_data,
    output logic              t_valid,
    output logic [7:0]        t_data,
    input  logic              tx_done,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              load_done,
    output logic              load_err,
    output logic [2:0]        dbg_state
);

    // Largest legal program; 33 bits so 2**ADDR_W is representable for any ADDR_W <= 32
    localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_W;

    logic [2:0]        state_q, state_d;
    logic              pending_q, pending_d;
    logic [31:0]       len_q, len_d;
    logic [ADDR_W:0]   k_q, k_d, k_inc;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic [7:0]        t_data_q, t_data_d;
    logic              load_err_q, load_err_d;

    logic              req_ok, rx_ok, tx_ok;
    logic              asm_clear, asm_word_valid;
    logic [31:0]       asm_word;

    uart_loader_byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .byte_valid (rx_ok),
        .byte_in    (r_data),
        .word       (asm_word),
        .word_valid (asm_word_valid)
    );

    // Request issue and completion qualification
    always_comb begin
        req_ok  = !rst && u_ready && !pending_q;
        r_valid = req_ok && is_rx_state(state_q);
        t_valid = req_ok && is_tx_state(state_q);
        rx_ok   = rx_done && pending_q && is_rx_state(state_q);
        tx_ok   = tx_done && pending_q && is_tx_state(state_q);
        pending_d = pending_q;
        if (r_valid || t_valid) begin
            pending_d = 1'b1;
        end else if (rx_ok || tx_ok) begin
            pending_d = 1'b0;
        end
    end

    // Load sequencing, word counter and imem/status register updates
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        k_d          = k_q;
        k_inc        = k_q + (ADDR_W + 1)'(1);
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        t_data_d     = t_data_q;
        load_err_d   = load_err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LEN;
                    k_d     = '0;
                end
            end
            ST_LEN: begin
                if (asm_word_valid) begin
                    len_d = asm_word;
                    if (asm_word == 32'd0) begin
                        state_d = ST_ACK;
                    end else if ({1'b0, asm_word} > MAX_WORDS) begin
                        state_d    = ST_ERR;
                        load_err_d = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // Register the write now so imem_we is high exactly during WRITE
                if (asm_word_valid) begin
                    state_d      = ST_WRITE;
                    imem_we_d    = 1'b1;
                    imem_addr_d  = k_q[ADDR_W-1:0];
                    imem_wdata_d = asm_word;
                end
            end
            ST_WRITE: begin
                k_d     = k_inc;
                state_d = (32'(k_inc) == len_q) ? ST_ACK : ST_DATA;
            end
            ST_ACK, ST_ERR: begin
                if (tx_ok) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        // t_data is loaded on entry so it is already stable when t_valid fires
        if (state_d != state_q) begin
            if (state_d == ST_ACK) t_data_d = ACK_BYTE;
            if (state_d == ST_ERR) t_data_d = ERR_BYTE;
        end
        asm_clear = (state_d != state_q) && is_rx_state(state_d);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pending_q    <= 1'b0;
            len_q        <= 32'd0;
            k_q          <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            t_data_q     <= 8'd0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            len_q        <= len_d;
            k_q          <= k_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            t_data_q     <= t_data_d;
            load_err_q   <= load_err_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign t_data     = t_data_q;
    assign load_err   = load_err_q;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign load_done  = (state_q == ST_DONE);
    assign dbg_state  = state_q;

endmodule
